alu_sequencer: RTL

Multi-cycle execution controller for the DCPU-16 ALU. It accepts one basic opcode with operands from decode over a valid/ready handshake and drives the combinational ALU with registered, stable inputs for the architectural cycle cost of that opcode. It also owns the EX register, captures the result and the IF-condition outcome, and presents them to writeback over a second valid/ready handshake.

---
 rtl/alu_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle DCPU-16 ALU execution controller with EX register
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_op,
    input  logic [15:0] issue_b,
    input  logic [15:0] issue_a,
    input  logic        flush,
    input  logic        ex_wr_en,
    input  logic [15:0] ex_wr_data,
    output logic [15:0] ex_q,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_exin,
    input  logic [15:0] alu_q,
    input  logic [15:0] alu_exout,
    input  logic        alu_cl,
    input  logic        alu_eq,
    input  logic        alu_lt,
    input  logic        alu_un,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_q,
    output logic        res_wr,
    output logic        res_skip,
    output logic        res_illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       ext_q, ext_d;
    logic       issue_take;
    logic       complete;
    logic       skip_set;

    // Architectural cycle cost; unknown opcodes cost one cycle and are flagged illegal.
    function automatic logic [1:0] op_cost(input logic [4:0] op);
        logic [1:0] c;
        c = 2'd1;
        if ((op >= 5'h02 && op <= 5'h05) || (op >= 5'h10 && op <= 5'h17))
            c = 2'd2;
        else if ((op >= 5'h06 && op <= 5'h09) || op == 5'h1A || op == 5'h1B)
            c = 2'd3;
        return c;
    endfunction

    function automatic logic op_writes(input logic [4:0] op);
        return (op >= 5'h02 && op <= 5'h0F) || op == 5'h1A || op == 5'h1B;
    endfunction

    function automatic logic op_sets_ex(input logic [4:0] op);
        return (op >= 5'h02 && op <= 5'h07) || (op >= 5'h0D && op <= 5'h0F)
               || op == 5'h1A || op == 5'h1B;
    endfunction

    function automatic logic op_is_if(input logic [4:0] op);
        return op >= 5'h10 && op <= 5'h17;
    endfunction

    function automatic logic op_illegal(input logic [4:0] op);
        return !(op_writes(op) || op_is_if(op));
    endfunction

    // IF pass condition, indexed by the low three opcode bits (IFB..IFU).
    function automatic logic if_pass(input logic [2:0] sel, input logic cl, input logic eq,
                                     input logic lt, input logic un);
        logic p;
        case (sel)
            3'd0:    p = !cl;
            3'd1:    p = cl;
            3'd2:    p = eq;
            3'd3:    p = !eq;
            3'd4:    p = !eq && !lt;
            3'd5:    p = !eq && !un;
            3'd6:    p = lt;
            default: p = un;
        endcase
        return p;
    endfunction

    assign issue_ready = (state_q == S_IDLE);

    // Next-state logic: issue, countdown with optional IF-fail extension, result handoff.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ext_d      = ext_q;
        issue_take = 1'b0;
        complete   = 1'b0;
        skip_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue_valid && !flush) begin
                    issue_take = 1'b1;
                    state_d    = S_EXEC;
                    cnt_d      = op_cost(issue_op) - 2'd1;
                    ext_d      = 1'b0;
                end
            end
            S_EXEC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else if (op_is_if(alu_op) && !ext_q &&
                             !if_pass(alu_op[2:0], alu_cl, alu_eq, alu_lt, alu_un)) begin
                    ext_d    = 1'b1;
                    skip_set = 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ext_q   <= ext_d;
        end
    end

    // ALU operand latches and result capture; ALU inputs only move on issue acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_op      <= 5'd0;
            alu_a       <= 16'd0;
            alu_b       <= 16'd0;
            alu_exin    <= 16'd0;
            res_q       <= 16'd0;
            res_valid   <= 1'b0;
            res_wr      <= 1'b0;
            res_skip    <= 1'b0;
            res_illegal <= 1'b0;
        end else begin
            if (issue_take) begin
                alu_op      <= issue_op;
                alu_a       <= issue_a;
                alu_b       <= issue_b;
                alu_exin    <= ex_q;
                res_skip    <= 1'b0;
                res_wr      <= 1'b0;
                res_illegal <= 1'b0;
            end
            if (skip_set)
                res_skip <= 1'b1;
            if (complete) begin
                res_q       <= alu_q;
                res_wr      <= op_writes(alu_op);
                res_illegal <= op_illegal(alu_op);
                res_valid   <= 1'b1;
            end else if (state_q == S_DONE && (flush || res_ready)) begin
                res_valid <= 1'b0;
            end
        end
    end

    // EX register: an explicit write beats the ALU side effect on the same edge.
    always_ff @(posedge clk) begin
        if (reset)
            ex_q <= 16'd0;
        else if (ex_wr_en)
            ex_q <= ex_wr_data;
        else if (complete && op_sets_ex(alu_op))
            ex_q <= alu_exout;
    end

endmodule
